// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, response error codes, issue-stage
// state encoding and opcode classification helpers.
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_SLL  = 5'b00010;
    localparam logic [4:0] OP_XOR  = 5'b00011;
    localparam logic [4:0] OP_SRL  = 5'b00100;
    localparam logic [4:0] OP_SRA  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_AND  = 5'b00111;
    localparam logic [4:0] OP_SLTU = 5'b01000;
    localparam logic [4:0] OP_BNE  = 5'b01001;
    localparam logic [4:0] OP_BEQ  = 5'b01010;
    localparam logic [4:0] OP_LUI  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01100;
    localparam logic [4:0] OP_BLT  = 5'b01101;
    localparam logic [4:0] OP_BGE  = 5'b01110;
    localparam logic [4:0] OP_BLTU = 5'b10000;
    localparam logic [4:0] OP_BGEU = 5'b10001;
    localparam logic [4:0] OP_DIV  = 5'b10010;
    localparam logic [4:0] OP_REM  = 5'b10100;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } issue_state_e;

    function automatic logic is_multicycle(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_legal(input logic [4:0] op);
        logic w_legal;
        case (op)
            OP_ADD, OP_SUB, OP_SLL, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
            OP_SLTU, OP_BNE, OP_BEQ, OP_LUI, OP_MUL, OP_BLT, OP_BGE,
            OP_BLTU, OP_BGEU, OP_DIV, OP_REM: w_legal = 1'b1;
            default:                          w_legal = 1'b0;
        endcase
        return w_legal;
    endfunction

endpackage

// File: rtl/alu_op_issue.sv
// Issue stage in front of the ALU: accepts handshaked commands, sequences the
// ALU for single- or multi-cycle latency, and returns a handshaked response.
module alu_op_issue
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [4:0]        cmd_opcode,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic [4:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_start,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_done,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [1:0]        rsp_err,
    output logic [31:0]       op_count
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    issue_state_e      r_state;
    issue_state_e      w_next_state;

    logic [4:0]        r_alu_opcode;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic              r_alu_start;
    logic [DATA_W-1:0] r_rsp_result;
    logic [TAG_W-1:0]  r_rsp_tag;
    logic [1:0]        r_rsp_err;
    logic [31:0]       r_op_count;
    logic [CNT_W-1:0]  r_wait_cnt;

    logic              w_cmd_accept;
    logic              w_rsp_accept;
    logic              w_op_legal;
    logic              w_op_multi;
    logic              w_issued_multi;
    logic              w_timeout;
    logic              w_rsp_load;
    logic [DATA_W-1:0] w_rsp_result_d;
    logic [1:0]        w_rsp_err_d;

    assign w_cmd_accept   = cmd_valid && (r_state == ST_IDLE);
    assign w_rsp_accept   = rsp_ready && (r_state == ST_RESP);
    assign w_op_legal     = is_legal(cmd_opcode);
    assign w_op_multi     = is_multicycle(cmd_opcode);
    assign w_issued_multi = is_multicycle(r_alu_opcode);
    assign w_timeout      = (r_wait_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state plus the response-register load decision; alu_done is only
    // looked at in WAIT so late completions are dropped.
    always_comb begin
        w_next_state   = r_state;
        w_rsp_load     = 1'b0;
        w_rsp_result_d = '0;
        w_rsp_err_d    = ERR_OK;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (w_op_legal) begin
                        w_next_state = ST_ISSUE;
                    end else begin
                        w_next_state = ST_RESP;
                        w_rsp_load   = 1'b1;
                        w_rsp_err_d  = ERR_ILLEGAL;
                    end
                end
            end
            ST_ISSUE: begin
                if (w_issued_multi) begin
                    w_next_state = ST_WAIT;
                end else begin
                    w_next_state   = ST_RESP;
                    w_rsp_load     = 1'b1;
                    w_rsp_result_d = alu_result;
                end
            end
            ST_WAIT: begin
                if (alu_done) begin
                    w_next_state   = ST_RESP;
                    w_rsp_load     = 1'b1;
                    w_rsp_result_d = alu_result;
                end else if (w_timeout) begin
                    w_next_state = ST_RESP;
                    w_rsp_load   = 1'b1;
                    w_rsp_err_d  = ERR_TIMEOUT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_opcode <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_start  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_tag    <= '0;
            r_rsp_err    <= ERR_OK;
            r_op_count   <= '0;
            r_wait_cnt   <= '0;
        end else begin
            r_alu_start <= 1'b0;
            // Illegal opcodes never reach the ALU bus; it keeps the last legal op.
            if (w_cmd_accept && w_op_legal) begin
                r_alu_opcode <= cmd_opcode;
                r_alu_a      <= cmd_a;
                r_alu_b      <= cmd_b;
                r_alu_start  <= w_op_multi;
            end
            if (w_cmd_accept) begin
                r_rsp_tag <= cmd_tag;
            end
            if (w_rsp_load) begin
                r_rsp_result <= w_rsp_result_d;
                r_rsp_err    <= w_rsp_err_d;
            end
            if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_rsp_accept) begin
                r_op_count <= r_op_count + 32'd1;
            end
        end
    end

    assign cmd_ready  = (r_state == ST_IDLE);
    assign rsp_valid  = (r_state == ST_RESP);
    assign alu_opcode = r_alu_opcode;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_start  = r_alu_start;
    assign rsp_result = r_rsp_result;
    assign rsp_tag    = r_rsp_tag;
    assign rsp_err    = r_rsp_err;
    assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed bench for alu_op_issue: a tiny ALU stand-in, hand-computed
// expectations, and a single comparison task feeding the summary.
module tb_alu_op_issue;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_opcode;
    logic [63:0] cmd_a;
    logic [63:0] cmd_b;
    logic [3:0]  cmd_tag;
    logic [4:0]  alu_opcode;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic        alu_start;
    logic [63:0] alu_result;
    logic        alu_done;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_result;
    logic [3:0]  rsp_tag;
    logic [1:0]  rsp_err;
    logic [31:0] op_count;

    int unsigned n_cmp;
    int unsigned n_err;

    alu_op_issue #(
        .DATA_W (64),
        .TAG_W  (4),
        .TIMEOUT(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_opcode(cmd_opcode),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_tag   (cmd_tag),
        .alu_opcode(alu_opcode),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_start (alu_start),
        .alu_result(alu_result),
        .alu_done  (alu_done),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_result(rsp_result),
        .rsp_tag   (rsp_tag),
        .rsp_err   (rsp_err),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Minimal ALU stand-in covering only the opcodes exercised here.
    always_comb begin
        alu_result = '0;
        case (alu_opcode)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            OP_MUL:  alu_result = alu_a * alu_b;
            OP_DIV:  alu_result = (alu_b != 0) ? alu_a / alu_b : '1;
            OP_REM:  alu_result = (alu_b != 0) ? alu_a % alu_b : alu_a;
            default: alu_result = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] tag);
        chk("cmd_ready_pre", 64'(cmd_ready), 64'd1);
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        cmd_tag    = tag;
        tick();
        cmd_valid  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_opcode = '0;
        cmd_a      = '0;
        cmd_b      = '0;
        cmd_tag    = '0;
        alu_done   = 1'b0;
        rsp_ready  = 1'b1;
        tick();
        tick();
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_alu_start", 64'(alu_start), 64'd0);
        chk("rst_op_count",  64'(op_count),  64'd0);
        chk("rst_rsp_err",   64'(rsp_err),   64'd0);
        rst = 1'b0;
        tick();
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // ADD 17171 + 65432, tag 3
        issue(OP_ADD, 64'd17171, 64'd65432, 4'd3);
        chk("add_opcode",    64'(alu_opcode), 64'd0);
        chk("add_alu_a",     alu_a,           64'd17171);
        chk("add_alu_b",     alu_b,           64'd65432);
        chk("add_no_start",  64'(alu_start),  64'd0);
        chk("add_valid_t1",  64'(rsp_valid),  64'd0);
        chk("add_ready_t1",  64'(cmd_ready),  64'd0);
        tick();
        chk("add_valid_t2",  64'(rsp_valid),  64'd1);
        chk("add_result",    rsp_result,      64'd82603);
        chk("add_tag",       64'(rsp_tag),    64'd3);
        chk("add_err",       64'(rsp_err),    64'd0);
        tick();
        chk("add_count",     64'(op_count),   64'd1);
        chk("add_idle",      64'(cmd_ready),  64'd1);
        chk("add_valid_off", 64'(rsp_valid),  64'd0);

        // MUL 3 * 4, done 5 cycles after the start pulse
        issue(OP_MUL, 64'd3, 64'd4, 4'd7);
        chk("mul_opcode",    64'(alu_opcode), 64'd12);
        chk("mul_start",     64'(alu_start),  64'd1);
        tick();
        chk("mul_start_off", 64'(alu_start),  64'd0);
        tick();
        tick();
        tick();
        tick();
        chk("mul_wait",      64'(rsp_valid),  64'd0);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        chk("mul_valid",     64'(rsp_valid),  64'd1);
        chk("mul_result",    rsp_result,      64'd12);
        chk("mul_tag",       64'(rsp_tag),    64'd7);
        chk("mul_err",       64'(rsp_err),    64'd0);
        tick();
        chk("mul_count",     64'(op_count),   64'd2);

        // Illegal opcode 01111
        issue(5'b01111, 64'd99, 64'd1, 4'd9);
        chk("ill_no_start",  64'(alu_start),  64'd0);
        chk("ill_valid_t1",  64'(rsp_valid),  64'd1);
        chk("ill_err",       64'(rsp_err),    64'd1);
        chk("ill_result",    rsp_result,      64'd0);
        chk("ill_tag",       64'(rsp_tag),    64'd9);
        tick();
        chk("ill_count",     64'(op_count),   64'd3);

        // DIV 15 / 7 with no done: timeout after 16 WAIT cycles
        rsp_ready = 1'b0;
        issue(OP_DIV, 64'd15, 64'd7, 4'd2);
        chk("div_start",     64'(alu_start),  64'd1);
        for (int i = 0; i < 16; i++) begin
            tick();
        end
        chk("div_wait_last", 64'(rsp_valid),  64'd0);
        tick();
        chk("div_valid",     64'(rsp_valid),  64'd1);
        chk("div_err",       64'(rsp_err),    64'd2);
        chk("div_result",    rsp_result,      64'd0);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        chk("div_late_res",  rsp_result,      64'd0);
        chk("div_late_err",  64'(rsp_err),    64'd2);
        chk("div_late_val",  64'(rsp_valid),  64'd1);
        rsp_ready = 1'b1;
        tick();
        chk("div_count",     64'(op_count),   64'd4);
        chk("div_idle",      64'(cmd_ready),  64'd1);

        // SUB 45 - 13 with response back-pressure
        rsp_ready = 1'b0;
        issue(OP_SUB, 64'd45, 64'd13, 4'd4);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("sub_hold_val", 64'(rsp_valid), 64'd1);
            chk("sub_hold_res", rsp_result,     64'd32);
            chk("sub_hold_rdy", 64'(cmd_ready), 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("sub_idle",      64'(cmd_ready),  64'd1);
        chk("sub_valid_off", 64'(rsp_valid),  64'd0);
        chk("sub_count",     64'(op_count),   64'd5);

        // Reset during WAIT of REM 15 % 7
        issue(OP_REM, 64'd15, 64'd7, 4'd6);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rr_opcode",     64'(alu_opcode), 64'd0);
        chk("rr_alu_a",      alu_a,           64'd0);
        chk("rr_alu_b",      alu_b,           64'd0);
        chk("rr_start",      64'(alu_start),  64'd0);
        chk("rr_valid",      64'(rsp_valid),  64'd0);
        chk("rr_result",     rsp_result,      64'd0);
        chk("rr_tag",        64'(rsp_tag),    64'd0);
        chk("rr_count",      64'(op_count),   64'd0);
        rst = 1'b0;
        chk("rr_cmd_ready",  64'(cmd_ready),  64'd1);
        issue(OP_ADD, 64'd1, 64'd2, 4'd5);
        tick();
        chk("rr_add_valid",  64'(rsp_valid),  64'd1);
        chk("rr_add_result", rsp_result,      64'd3);
        chk("rr_add_tag",    64'(rsp_tag),    64'd5);
        tick();
        chk("rr_add_count",  64'(op_count),   64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
